// File: rtl/pe_pkg.sv
// pe_pkg: shared sizing, types and FSM encoding for the PE feeder slice.
//   LANES  : entries per group issued to the reducer
//   DIMS   : coordinate fields per address
//   ADDR_W : bits per coordinate field
//   DATA_W : weight / activation width
package pe_pkg;

    localparam int LANES  = 3;
    localparam int DIMS   = 3;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 16;
    localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int GCNT_W = 16;

    // Address is packed {d2,d1,d0}; element [0] is d0.
    typedef logic [DIMS-1:0][ADDR_W-1:0] pe_addr_t;
    typedef logic [DATA_W-1:0]           pe_data_t;
    typedef logic [CNT_W-1:0]            lane_idx_t;
    typedef logic [GCNT_W-1:0]           group_cnt_t;

    localparam lane_idx_t LAST_LANE = lane_idx_t'(LANES - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DONE    = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// pe_feeder_if: bundles the upstream entry stream and the reducer-facing
// group bus of the PE feeder.
//   Upstream : i_valid/o_ready handshake carrying i_addr, i_w, i_ia, i_last
//   Reducer  : o_start pulse with o_addr/o_w/o_ia lanes, i_finish back
//   Status   : o_done pulse, o_group_cnt
// modport master : the feeder itself
// modport slave  : the environment (entry fetch logic plus reducer)
interface pe_feeder_if;
    import pe_pkg::*;

    logic                   i_valid;
    logic                   o_ready;
    pe_addr_t               i_addr;
    pe_data_t               i_w;
    pe_data_t               i_ia;
    logic                   i_last;
    logic                   o_start;
    pe_addr_t [LANES-1:0]   o_addr;
    pe_data_t [LANES-1:0]   o_w;
    pe_data_t [LANES-1:0]   o_ia;
    logic                   i_finish;
    logic                   o_done;
    group_cnt_t             o_group_cnt;

    modport master (
        input  i_valid, i_addr, i_w, i_ia, i_last, i_finish,
        output o_ready, o_start, o_addr, o_w, o_ia, o_done, o_group_cnt
    );

    modport slave (
        output i_valid, i_addr, i_w, i_ia, i_last, i_finish,
        input  o_ready, o_start, o_addr, o_w, o_ia, o_done, o_group_cnt
    );

endinterface

// File: rtl/pe_lane_collector.sv
// pe_lane_collector: lane registers and write index for the PE feeder.
//   clk, rst   : clock, synchronous active-high reset
//   wr_en      : an entry is accepted this cycle
//   group_end  : the accepted entry closes the group (index returns to 0)
//   clear      : zero all lanes (group consumed by the reducer)
//   addr/w/ia  : entry fields written into the current lane
//   lane_*     : registered lane contents driven to the reducer
//   lane_cnt   : lane the next accepted entry goes to
// Lanes are zero between groups, so a group closed early by a last entry
// carries zero-padded tail lanes without any extra padding step.
module pe_lane_collector
    import pe_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic                 group_end,
    input  logic                 clear,
    input  pe_addr_t             addr,
    input  pe_data_t             w,
    input  pe_data_t             ia,
    output pe_addr_t [LANES-1:0] lane_addr,
    output pe_data_t [LANES-1:0] lane_w,
    output pe_data_t [LANES-1:0] lane_ia,
    output lane_idx_t            lane_cnt
);

    pe_addr_t [LANES-1:0] lane_addr_r;
    pe_data_t [LANES-1:0] lane_w_r;
    pe_data_t [LANES-1:0] lane_ia_r;
    lane_idx_t            lane_cnt_r;

    // Lane storage and write index: write on accept, zero on clear or reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_addr_r <= '0;
            lane_w_r    <= '0;
            lane_ia_r   <= '0;
            lane_cnt_r  <= lane_idx_t'(0);
        end else if (clear) begin
            lane_addr_r <= '0;
            lane_w_r    <= '0;
            lane_ia_r   <= '0;
            lane_cnt_r  <= lane_idx_t'(0);
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (lane_cnt_r == lane_idx_t'(i)) begin
                    lane_addr_r[i] <= addr;
                    lane_w_r[i]    <= w;
                    lane_ia_r[i]   <= ia;
                end else begin
                    lane_addr_r[i] <= lane_addr_r[i];
                    lane_w_r[i]    <= lane_w_r[i];
                    lane_ia_r[i]   <= lane_ia_r[i];
                end
            end
            lane_cnt_r <= group_end ? lane_idx_t'(0) : (lane_cnt_r + lane_idx_t'(1));
        end else begin
            lane_cnt_r <= lane_cnt_r;
        end
    end

    assign lane_addr = lane_addr_r;
    assign lane_w    = lane_w_r;
    assign lane_ia   = lane_ia_r;
    assign lane_cnt  = lane_cnt_r;

endmodule

// File: rtl/pe_feeder.sv
// pe_feeder: packs a serial stream of sparse (coordinate, weight, activation)
// entries into LANES-wide groups and issues each group to the PE reducer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : pe_feeder_if.master
//                  upstream  i_valid/o_ready, i_addr, i_w, i_ia, i_last
//                  reducer   o_start, o_addr, o_w, o_ia, i_finish
//                  status    o_done, o_group_cnt
// A group goes out when the last lane fills or a tile-final entry arrives;
// it is held on the lane outputs until the reducer reports finish. The
// group counter counts within a tile and is cleared after the done pulse.
module pe_feeder
    import pe_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    pe_feeder_if.master bus
);

    feeder_state_e        state_r;
    logic                 ready_r;
    logic                 start_r;
    logic                 done_r;
    logic                 last_flag_r;
    group_cnt_t           group_cnt_r;

    logic                 accept_s;
    logic                 group_end_s;
    logic                 clear_s;
    lane_idx_t            lane_cnt_s;
    pe_addr_t [LANES-1:0] lane_addr_s;
    pe_data_t [LANES-1:0] lane_w_s;
    pe_data_t [LANES-1:0] lane_ia_s;

    // ready_r is only ever high in COLLECT, so it alone qualifies an accept.
    assign accept_s    = bus.i_valid && ready_r;
    assign group_end_s = accept_s && ((lane_cnt_s == LAST_LANE) || bus.i_last);
    assign clear_s     = (state_r == ST_WAIT) && bus.i_finish;

    pe_lane_collector u_collector (
        .clk       (i_clk),
        .rst       (i_rst),
        .wr_en     (accept_s),
        .group_end (group_end_s),
        .clear     (clear_s),
        .addr      (bus.i_addr),
        .w         (bus.i_w),
        .ia        (bus.i_ia),
        .lane_addr (lane_addr_s),
        .lane_w    (lane_w_s),
        .lane_ia   (lane_ia_s),
        .lane_cnt  (lane_cnt_s)
    );

    // Feeder FSM with registered handshake, pulse and counter outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_COLLECT;
            ready_r     <= 1'b1;
            start_r     <= 1'b0;
            done_r      <= 1'b0;
            last_flag_r <= 1'b0;
            group_cnt_r <= group_cnt_t'(0);
        end else begin
            start_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (group_end_s) begin
                        // Count moves with the start pulse so the reducer
                        // sees the group number alongside its group.
                        state_r     <= ST_ISSUE;
                        ready_r     <= 1'b0;
                        start_r     <= 1'b1;
                        last_flag_r <= bus.i_last;
                        group_cnt_r <= group_cnt_r + group_cnt_t'(1);
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // A finish here belongs to no group of ours; ignore it.
                    state_r <= ST_WAIT;
                    ready_r <= 1'b0;
                end
                ST_WAIT: begin
                    if (bus.i_finish) begin
                        if (last_flag_r) begin
                            state_r <= ST_DONE;
                            ready_r <= 1'b0;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= ST_COLLECT;
                            ready_r <= 1'b1;
                        end
                    end else begin
                        ready_r <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r     <= ST_COLLECT;
                    ready_r     <= 1'b1;
                    last_flag_r <= 1'b0;
                    group_cnt_r <= group_cnt_t'(0);
                end
                default: begin
                    state_r     <= ST_COLLECT;
                    ready_r     <= 1'b1;
                    last_flag_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_ready     = ready_r;
    assign bus.o_start     = start_r;
    assign bus.o_done      = done_r;
    assign bus.o_group_cnt = group_cnt_r;
    assign bus.o_addr      = lane_addr_s;
    assign bus.o_w         = lane_w_s;
    assign bus.o_ia        = lane_ia_s;

endmodule

// File: tb/tb_pe_feeder.sv
// tb_pe_feeder: self-checking bench for pe_feeder. A table of entries with
// the expected start/done response drives most tiles; a reference packer
// pushes expected groups into a scoreboard queue that is popped on o_start.
module tb_pe_feeder;
    import pe_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] d2, d1, d0;
        logic [DATA_W-1:0] w, ia;
        logic              last;
        logic              exp_start;
        logic              exp_done;
        int                fin_delay;
    } vec_t;

    typedef struct packed {
        pe_addr_t [LANES-1:0] addr;
        pe_data_t [LANES-1:0] w;
        pe_data_t [LANES-1:0] ia;
        group_cnt_t           cnt;
    } grp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pe_feeder_if bus ();
    pe_feeder dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    grp_t sb_q[$];
    grp_t acc_grp;
    grp_t last_grp;
    int   fill = 0;
    logic [15:0] m_cnt = 16'd0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d2, input int d1, input int d0, input int w,
                                input int ia, input logic last, input logic es,
                                input logic ed, input int fd);
        vec_t v;
        v.d2 = ADDR_W'(d2); v.d1 = ADDR_W'(d1); v.d0 = ADDR_W'(d0);
        v.w = DATA_W'(w); v.ia = DATA_W'(ia); v.last = last;
        v.exp_start = es; v.exp_done = ed; v.fin_delay = fd;
        return v;
    endfunction

    // Reference packer: fill lanes in order, close on full group or last.
    task automatic model_push(input vec_t e);
        acc_grp.addr[fill] = {e.d2, e.d1, e.d0};
        acc_grp.w[fill]    = e.w;
        acc_grp.ia[fill]   = e.ia;
        fill++;
        if (fill == LANES || e.last) begin
            m_cnt = m_cnt + 16'd1;
            acc_grp.cnt = m_cnt;
            sb_q.push_back(acc_grp);
            last_grp = acc_grp;
            acc_grp = '0;
            fill = 0;
            if (e.last) m_cnt = 16'd0;
        end
    endtask

    // Present one entry and hold it until accepted; returns edges waited.
    task automatic send(input vec_t e, output int edges);
        logic acc;
        acc = 1'b0;
        edges = 0;
        bus.i_valid = 1'b1;
        bus.i_addr  = {e.d2, e.d1, e.d0};
        bus.i_w     = e.w;
        bus.i_ia    = e.ia;
        bus.i_last  = e.last;
        while (!acc && edges < 50) begin
            acc = bus.o_ready;
            if (acc) model_push(e);
            @(posedge clk); #1;
            edges++;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        if (!acc) check("accept_timeout", 128'd0, 128'd1);
    endtask

    task automatic pulse_finish();
        bus.i_finish = 1'b1;
        @(posedge clk); #1;
        bus.i_finish = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        int ed;
        for (int i = lo; i <= hi; i++) begin
            send(vecs[i], ed);
            check("start_after_accept", 128'(bus.o_start), 128'(vecs[i].exp_start));
            if (vecs[i].exp_start) begin
                repeat (vecs[i].fin_delay) begin @(posedge clk); #1; end
                pulse_finish();
                check("done_after_finish", 128'(bus.o_done), 128'(vecs[i].exp_done));
                if (vecs[i].exp_done) begin
                    @(posedge clk); #1;
                    check("cnt_cleared_after_done", 128'(bus.o_group_cnt), 128'd0);
                    check("done_one_cycle", 128'(bus.o_done), 128'd0);
                end else begin
                    check("ready_after_finish", 128'(bus.o_ready), 128'd1);
                end
            end
        end
    endtask

    // Scoreboard: every start pulse must match the next expected group.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_start) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_start", 128'd1, 128'd0);
                end else begin
                    grp_t g;
                    g = sb_q.pop_front();
                    check("grp_addr", 128'(bus.o_addr), 128'(g.addr));
                    check("grp_w", 128'(bus.o_w), 128'(g.w));
                    check("grp_ia", 128'(bus.o_ia), 128'(g.ia));
                    check("grp_cnt", 128'(bus.o_group_cnt), 128'(g.cnt));
                end
            end
            if (bus.o_done) done_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ed;
        vec_t e;
        // tile A: three entries, last on third
        vecs[0]  = mk(0, 0, 0, 15, 3, 1'b0, 1'b0, 1'b0, 0);
        vecs[1]  = mk(1, 1, 1, 16, 2, 1'b0, 1'b0, 1'b0, 0);
        vecs[2]  = mk(2, 2, 2, 17, 1, 1'b1, 1'b1, 1'b1, 3);
        // tile B: five entries, second group padded in lane 2
        vecs[3]  = mk(3, 4, 5, 100, 1, 1'b0, 1'b0, 1'b0, 0);
        vecs[4]  = mk(6, 7, 8, 101, 2, 1'b0, 1'b0, 1'b0, 0);
        vecs[5]  = mk(9, 10, 11, 102, 3, 1'b0, 1'b1, 1'b0, 2);
        vecs[6]  = mk(12, 13, 14, 103, 4, 1'b0, 1'b0, 1'b0, 0);
        vecs[7]  = mk(15, 16, 17, 104, 5, 1'b1, 1'b1, 1'b1, 1);
        // tile C: single entry
        vecs[8]  = mk(5, 6, 7, 9, 4, 1'b1, 1'b1, 1'b1, 2);
        // tile D: four entries with extreme values, one-entry second group
        vecs[9]  = mk(20, 21, 22, 16'hFFFF, 16'h8000, 1'b0, 1'b0, 1'b0, 0);
        vecs[10] = mk(23, 24, 25, 1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
        vecs[11] = mk(26, 27, 28, 16'h1234, 16'hABCD, 1'b0, 1'b1, 1'b0, 1);
        vecs[12] = mk(127, 127, 127, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b1, 5);

        acc_grp = '0;
        last_grp = '0;
        bus.i_valid = 1'b0; bus.i_addr = '0; bus.i_w = '0; bus.i_ia = '0;
        bus.i_last = 1'b0; bus.i_finish = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_ready", 128'(bus.o_ready), 128'd1);
        check("rst_start", 128'(bus.o_start), 128'd0);
        check("rst_done", 128'(bus.o_done), 128'd0);
        check("rst_cnt", 128'(bus.o_group_cnt), 128'd0);
        check("rst_lanes", 128'({bus.o_addr, bus.o_w, bus.o_ia}), 128'd0);

        run_rows(0, 12);

        // Long wait: finish held off 20 cycles with an entry pending.
        e = mk(10, 11, 12, 7, 8, 1'b0, 1'b0, 1'b0, 0);
        send(e, ed);
        e = mk(13, 14, 15, 9, 10, 1'b0, 1'b0, 1'b0, 0);
        send(e, ed);
        e = mk(16, 17, 18, 11, 12, 1'b0, 1'b0, 1'b0, 0);
        send(e, ed);
        check("lw_start", 128'(bus.o_start), 128'd1);
        e = mk(30, 31, 32, 40, 41, 1'b1, 1'b0, 1'b0, 0);
        bus.i_valid = 1'b1;
        bus.i_addr = {e.d2, e.d1, e.d0}; bus.i_w = e.w; bus.i_ia = e.ia; bus.i_last = 1'b1;
        for (int c = 0; c < 20; c++) begin
            check("lw_ready_low", 128'(bus.o_ready), 128'd0);
            check("lw_lanes_stable", 128'({bus.o_addr, bus.o_w, bus.o_ia}),
                  128'({last_grp.addr, last_grp.w, last_grp.ia}));
            @(posedge clk); #1;
        end
        pulse_finish();
        check("lw_ready_after_finish", 128'(bus.o_ready), 128'd1);
        send(e, ed);
        check("lw_accept_latency", 128'(ed), 128'd1);
        check("lw_start2", 128'(bus.o_start), 128'd1);
        repeat (2) begin @(posedge clk); #1; end
        pulse_finish();
        check("lw_done", 128'(bus.o_done), 128'd1);

        // Finish pulsed during the ISSUE cycle must be ignored.
        e = mk(1, 2, 3, 4, 5, 1'b0, 1'b0, 1'b0, 0);
        send(e, ed);
        e = mk(4, 5, 6, 7, 8, 1'b0, 1'b0, 1'b0, 0);
        send(e, ed);
        e = mk(7, 8, 9, 10, 11, 1'b1, 1'b0, 1'b0, 0);
        send(e, ed);
        check("iss_start", 128'(bus.o_start), 128'd1);
        pulse_finish();
        check("iss_no_done", 128'(bus.o_done), 128'd0);
        repeat (3) begin @(posedge clk); #1; end
        check("iss_still_wait", 128'({bus.o_ready, bus.o_done}), 128'd0);
        pulse_finish();
        check("iss_done", 128'(bus.o_done), 128'd1);
        @(posedge clk); #1;

        // Reset while waiting on the second group of a tile.
        for (int i = 0; i < 6; i++) begin
            e = mk(40 + i, 50 + i, 60 + i, 200 + i, 300 + i, 1'b0, 1'b0, 1'b0, 0);
            send(e, ed);
            if (i == 2) begin
                repeat (2) begin @(posedge clk); #1; end
                pulse_finish();
            end
        end
        check("rw_start2", 128'(bus.o_start), 128'd1);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_grp = '0; fill = 0; m_cnt = 16'd0;
        check("rw_lanes_zero", 128'({bus.o_addr, bus.o_w, bus.o_ia}), 128'd0);
        check("rw_cnt_zero", 128'(bus.o_group_cnt), 128'd0);
        check("rw_ready", 128'(bus.o_ready), 128'd1);
        check("rw_start_done", 128'({bus.o_start, bus.o_done}), 128'd0);
        @(posedge clk); #1;
        check("rw_no_done_after", 128'(bus.o_done), 128'd0);

        run_rows(0, 2);

        repeat (3) begin @(posedge clk); #1; end
        check("done_count", 128'(done_cnt), 128'd7);
        check("sb_drained", 128'(sb_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
